// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by alu_iter and its tests
package alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_MULHU = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_REMU  = 4'b1011;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative unsigned multiply / restoring divide, one bit per cycle
// Ports: clk, reset (sync, active-high); start loads op/a/b; op[1]=divide, op[0]=high half
// (MULHU) or remainder (REMU); done pulses for one cycle with result valid, XLEN cycles after start.
module alu_muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    // acc holds {hi, lo}: for MUL the multiplier starts in lo and is shifted out as the
    // product shifts in; for DIV it is {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   den_q, diff;
    logic [XLEN:0]     mul_sum, r_sh;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        op_q;
    logic              busy_q, step, ge;
    always_comb begin
        step    = busy_q && cnt_q != CW'(XLEN);
        done    = busy_q && !step;
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, den_q} : '0);
        r_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge      = r_sh >= {1'b0, den_q};
        // when ge, the true difference is below den_q so the low XLEN bits suffice
        diff    = r_sh[XLEN-1:0] - den_q;
        acc_d   = op_q[1] ? {ge ? diff : r_sh[XLEN-1:0], acc_q[XLEN-2:0], ge}
                          : {mul_sum, acc_q[XLEN-1:1]};
        result  = op_q[0] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            den_q  <= '0;
            op_q   <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            op_q   <= op;
            den_q  <= op[1] ? b : a;
            acc_q  <= {{XLEN{1'b0}}, op[1] ? a : b};
        end else if (step) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + CW'(1);
        end else begin
            busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with registered result and optional iterative MUL/DIV
// Ports: clk, reset (sync, active-high); in_valid/in_ready request with alu_control, rs1, rs2;
// out_valid/out_ready result with rd and alu_zero (rd == 0).
// Define ALU_ITER_MULDIV_EN to build MUL/MULHU/DIVU/REMU; otherwise those codes act as unknown.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            alu_zero
);
    state_t          state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d, quick;
    logic            zero_q, zero_d;
`ifdef ALU_ITER_MULDIV_EN
    logic            md_start, md_done, is_md, is_div, iter;
    logic [XLEN-1:0] md_result;
    assign is_md  = alu_control[3:2] == 2'b10;
    assign is_div = is_md && alu_control[1];
    // divide by zero resolves in one cycle instead of iterating
    assign iter   = is_md && !(is_div && rs2 == '0);
    alu_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
        .clk(clk), .reset(reset), .start(md_start), .op(alu_control[1:0]),
        .a(rs1), .b(rs2), .done(md_done), .result(md_result)
    );
`endif
    always_comb begin
        quick = alu_control == ALU_AND  ? rs1 & rs2 :
                alu_control == ALU_OR   ? rs1 | rs2 :
                alu_control == ALU_ADD  ? rs1 + rs2 :
                alu_control == ALU_SUB  ? rs1 - rs2 :
`ifdef ALU_ITER_MULDIV_EN
                alu_control == ALU_DIVU ? '1 :
                alu_control == ALU_REMU ? rs1 :
`endif
                '0;
    end
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        zero_d   = zero_q;
        in_ready = state_q == S_IDLE && !reset;
`ifdef ALU_ITER_MULDIV_EN
        md_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (in_valid && in_ready) begin
`ifdef ALU_ITER_MULDIV_EN
                if (iter) begin
                    md_start = 1'b1;
                    state_d  = is_div ? S_DIV : S_MUL;
                end else
`endif
                begin
                    rd_d    = quick;
                    zero_d  = quick == '0;
                    state_d = S_DONE;
                end
            end
`ifdef ALU_ITER_MULDIV_EN
            S_MUL, S_DIV: if (md_done) begin
                rd_d    = md_result;
                zero_d  = md_result == '0;
                state_d = S_DONE;
            end
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            zero_q  <= zero_d;
        end
    end
    assign out_valid = state_q == S_DONE;
    assign rd        = rd_q;
    assign alu_zero  = zero_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter at XLEN=64
module tb_alu_iter;
    import alu_pkg::*;
    localparam int XLEN = 64;
`ifdef ALU_ITER_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int LMD = MD ? XLEN + 1 : 1;
    logic            clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]      alu_control = '0;
    logic [XLEN-1:0] rs1 = '0, rs2 = '0;
    logic            in_ready, out_valid, alu_zero;
    logic [XLEN-1:0] rd;
    int              vecs = 0, errs = 0;

    alu_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .out_ready(out_ready), .rd(rd), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int n;
        bit idle_ok;
        @(negedge clk);
        chk({tag, " in_ready"}, XLEN'(in_ready), 1);
        in_valid = 1'b1; alu_control = op; rs1 = a; rs2 = b;
        @(posedge clk);
        #1 in_valid = 1'b0; alu_control = ~op; rs1 = ~a; rs2 = ~b;
        n = 0;
        idle_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (in_ready) idle_ok = 1'b0;
        end while (!out_valid && n < 200);
        chk({tag, " latency"}, XLEN'(n), XLEN'(lat));
        chk({tag, " busy"}, XLEN'(idle_ok), 1);
        chk({tag, " rd"}, rd, exp);
        chk({tag, " zero"}, XLEN'(alu_zero), XLEN'(exp == '0));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " handoff out_valid"}, XLEN'(out_valid), 0);
        chk({tag, " handoff in_ready"}, XLEN'(in_ready), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", XLEN'(out_valid), 0);
        chk("rst rd", rd, 0);
        chk("rst zero", XLEN'(alu_zero), 0);
        chk("rst in_ready", XLEN'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", XLEN'(in_ready), 1);

        run("AND", ALU_AND, {16{4'hA, 4'h5}}, {16{4'h5, 4'hA}}, 64'h0, 1);              handoff("AND");
        run("OR", ALU_OR, {16{4'hA, 4'h5}}, {16{4'h5, 4'hA}}, '1, 1);                    handoff("OR");
        run("ADD", ALU_ADD, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1);                          handoff("ADD");
        run("SUB0", ALU_SUB, 64'd0, 64'd0, 64'd0, 1);                                     handoff("SUB0");
        run("SUB57", ALU_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);                  handoff("SUB57");
        run("UNK", 4'b1111, 64'd3, 64'd4, 64'd0, 1);                                      handoff("UNK");
        run("MUL", ALU_MUL, 64'h1_0000_0001, 64'h1_0000_0001,
            MD ? 64'h0000_0002_0000_0001 : 64'd0, LMD);                                   handoff("MUL");
        run("MULHU", ALU_MULHU, '1, '1, MD ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0, LMD);       handoff("MULHU");
        run("DIVU", ALU_DIVU, 64'd100, 64'd7, MD ? 64'd14 : 64'd0, LMD);                  handoff("DIVU");
        run("REMU", ALU_REMU, 64'd100, 64'd7, MD ? 64'd2 : 64'd0, LMD);                   handoff("REMU");
        run("DIVU0", ALU_DIVU, 64'd5, 64'd0, MD ? '1 : 64'd0, 1);                         handoff("DIVU0");
        run("REMU0", ALU_REMU, 64'h1234, 64'd0, MD ? 64'h1234 : 64'd0, 1);               handoff("REMU0");

        // backpressure: result must hold and a new request must be dropped
        run("BP", ALU_ADD, 64'd1, 64'd2, 64'd3, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2); alu_control = ALU_OR; rs1 = '1; rs2 = '1;
            @(negedge clk);
            chk("BP hold out_valid", XLEN'(out_valid), 1);
            chk("BP hold rd", rd, 64'd3);
            chk("BP hold zero", XLEN'(alu_zero), 0);
            chk("BP hold in_ready", XLEN'(in_ready), 0);
        end
        in_valid = 1'b0;
        handoff("BP");

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; alu_control = ALU_MUL; rs1 = 64'd3; rs2 = 64'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1 chk("RST in_ready during reset", XLEN'(in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("RST out_valid", XLEN'(out_valid), 0);
        chk("RST in_ready", XLEN'(in_ready), 1);
        chk("RST rd", rd, 0);
        chk("RST zero", XLEN'(alu_zero), 0);
        run("DIV93", ALU_DIVU, 64'd9, 64'd3, MD ? 64'd3 : 64'd0, LMD);                    handoff("DIV93");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
